// File: rtl/enc_pkg.sv
// Shared widths and types for the registered 8-to-3 priority encoder.
package enc_pkg;
    localparam int DIN_W = 8;
    localparam int Y_W   = $clog2(DIN_W);

    typedef logic [DIN_W-1:0] din_t;
    typedef logic [Y_W-1:0]   idx_t;
endpackage

// File: rtl/enc8to3_sync_if.sv
// Request vector in, registered index/flags out; master drives requests, slave is the encoder.
interface enc8to3_sync_if;
    enc_pkg::din_t Din;
    logic          EN;
    enc_pkg::idx_t Y;
    logic          valid;
    logic          multi;

    modport master (
        output Din,
        output EN,
        input  Y,
        input  valid,
        input  multi
    );

    modport slave (
        input  Din,
        input  EN,
        output Y,
        output valid,
        output multi
    );
endinterface

// File: rtl/enc8to3_core.sv
// Combinational priority encoder: index of the highest set bit plus any/several-bits flags.
module enc8to3_core
    import enc_pkg::*;
(
    input  din_t Din,
    input  logic EN,
    output idx_t y_nxt,
    output logic valid_nxt,
    output logic multi_nxt
);

    logic any_set;
    logic several_set;

    assign any_set = |Din;
    // Clearing the lowest set bit leaves something only when two or more bits were set.
    assign several_set = |(Din & din_t'(Din - din_t'(1)));

    // Ascending scan so the highest set bit is the last to write the index.
    always_comb begin
        y_nxt = '0;
        if (EN) begin
            for (int i = 0; i < DIN_W; i++) begin
                if (Din[i]) begin
                    y_nxt = idx_t'(i);
                end
            end
        end
    end

    assign valid_nxt = EN & any_set;
    assign multi_nxt = EN & several_set;

endmodule

// File: rtl/enc8to3_sync.sv
// Registered 8-to-3 priority encoder: one-cycle latency, synchronous active-high reset.
module enc8to3_sync
    import enc_pkg::*;
#(
    parameter int DIN_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    enc8to3_sync_if.slave        bus
);

    generate
        if (DIN_W != 8) begin : g_bad_width
            $error("enc8to3_sync supports only DIN_W = 8");
        end
    endgenerate

    idx_t y_nxt;
    logic valid_nxt;
    logic multi_nxt;

    enc8to3_core u_core (
        .Din       (bus.Din),
        .EN        (bus.EN),
        .y_nxt     (y_nxt),
        .valid_nxt (valid_nxt),
        .multi_nxt (multi_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.Y     <= '0;
            bus.valid <= 1'b0;
            bus.multi <= 1'b0;
        end else begin
            bus.Y     <= y_nxt;
            bus.valid <= valid_nxt;
            bus.multi <= multi_nxt;
        end
    end

endmodule

// File: tb/tb_enc8to3_sync.sv
// Scoreboard bench for enc8to3_sync: expected results queued at drive time, popped one cycle later.
module tb_enc8to3_sync;
    import enc_pkg::*;

    typedef struct packed {
        logic [2:0] y;
        logic       valid;
        logic       multi;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;
    exp_t sb[$];

    enc8to3_sync_if bus ();

    enc8to3_sync #(.DIN_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent reference: scan from the top bit down and count bits directly.
    function automatic exp_t model(input logic r, input logic [7:0] d, input logic e);
        exp_t res;
        logic found;
        res   = '0;
        found = 1'b0;
        if (!r && e && d != 8'h00) begin
            res.valid = 1'b1;
            res.multi = ($countones(d) >= 2);
            for (int i = 7; i >= 0; i--) begin
                if (d[i] && !found) begin
                    res.y = 3'(i);
                    found = 1'b1;
                end
            end
        end
        return res;
    endfunction

    task automatic check_output(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic apply_stimulus(input logic r, input logic e, input logic [7:0] d);
        exp_t want;
        @(negedge clk);
        rst     = r;
        bus.EN  = e;
        bus.Din = d;
        sb.push_back(model(r, d, e));
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
        end else begin
            want = sb.pop_front();
            check_output($sformatf("Y din=%02h en=%0b rst=%0b", d, e, r), 8'(bus.Y), 8'(want.y));
            check_output($sformatf("valid din=%02h en=%0b rst=%0b", d, e, r), 8'(bus.valid), 8'(want.valid));
            check_output($sformatf("multi din=%02h en=%0b rst=%0b", d, e, r), 8'(bus.multi), 8'(want.multi));
        end
    endtask

    initial begin
        logic [7:0] walk;
        n_checks = 0;
        n_fails  = 0;
        rst      = 1'b1;
        bus.EN   = 1'b1;
        bus.Din  = 8'hFF;

        // Reset held with all requests active, then first real result.
        apply_stimulus(1'b1, 1'b1, 8'hFF);
        apply_stimulus(1'b1, 1'b1, 8'hFF);
        apply_stimulus(1'b0, 1'b1, 8'hFF);

        // Disabled encoder ignores Din.
        apply_stimulus(1'b0, 1'b0, 8'b0000_0001);
        apply_stimulus(1'b0, 1'b0, 8'hFF);

        walk = 8'b0000_0001;
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1'b0, 1'b1, walk);
            walk = walk << 1;
        end

        apply_stimulus(1'b0, 1'b1, 8'b0000_0000);
        apply_stimulus(1'b0, 1'b1, 8'b0101_0010);
        apply_stimulus(1'b0, 1'b1, 8'b0000_0011);
        apply_stimulus(1'b0, 1'b1, 8'b0000_0001);

        // Reset arriving with a valid request wins; the request shows the cycle after.
        apply_stimulus(1'b1, 1'b1, 8'b0010_0000);
        apply_stimulus(1'b0, 1'b1, 8'b0010_0000);

        for (int i = 0; i < 40; i++) begin
            apply_stimulus(1'b0, 1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
